// File: rtl/dispense_inventory.sv
// dispense_inventory: per-slot stock tracking and 4-phase dispense handshake for the money block
module dispense_inventory #(
  parameter int NUM_ITEMS       = 8,
  parameter int CNT_W           = 4,
  parameter int MAX_STOCK       = 15,
  parameter int DISPENSE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           curIndex,
  input  logic                 reduceInventory,
  input  logic                 restock,
  output logic                 reduceInventoryDone,
  output logic                 fullInventory,
  output logic [CNT_W-1:0]     itemCount,
  output logic [NUM_ITEMS-1:0] motorEn,
  output logic                 emptyErr,
  output logic                 soldOut,
  output logic [15:0]          totalDispensed
);
  localparam int TW = $clog2(DISPENSE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, CHECK, DISPENSE, DONE_WAIT} state_t;
  state_t                 state_q;
  logic [3:0]             idx_q;
  logic [TW-1:0]          timer_q;
  logic [CNT_W-1:0]       cnt_q [NUM_ITEMS];
  logic                   done_q, err_q;
  logic [NUM_ITEMS-1:0]   motor_q;
  logic [15:0]            total_q;
  logic [CNT_W-1:0]       sel_cnt, idx_cnt;
  logic                   any_left;
  // Out-of-range indices never match a slot, so they read as an empty slot.
  always_comb begin
    sel_cnt  = '0;
    idx_cnt  = '0;
    any_left = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (curIndex == 4'(i)) sel_cnt = cnt_q[i];
      if (idx_q == 4'(i)) idx_cnt = cnt_q[i];
      any_left = any_left | (cnt_q[i] != '0);
    end
  end
  assign itemCount           = sel_cnt;
  assign fullInventory       = sel_cnt != '0;
  assign soldOut             = !any_left;
  assign reduceInventoryDone = done_q;
  assign motorEn             = motor_q;
  assign emptyErr            = err_q;
  assign totalDispensed      = total_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      motor_q <= '0;
      total_q <= '0;
      for (int i = 0; i < NUM_ITEMS; i++) cnt_q[i] <= CNT_W'(MAX_STOCK);
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (reduceInventory) begin
            idx_q   <= curIndex;
            state_q <= CHECK;
          end else if (restock) begin
            for (int i = 0; i < NUM_ITEMS; i++) cnt_q[i] <= CNT_W'(MAX_STOCK);
          end
        end
        CHECK: begin
          if (idx_cnt != '0) begin
            for (int i = 0; i < NUM_ITEMS; i++)
              if (idx_q == 4'(i)) cnt_q[i] <= cnt_q[i] - 1'b1;
            timer_q <= TW'(DISPENSE_CYCLES);
            motor_q <= NUM_ITEMS'(1) << idx_q;
            total_q <= (total_q == 16'hFFFF) ? total_q : total_q + 16'd1;
            state_q <= DISPENSE;
          end else begin
            err_q   <= 1'b1;
            state_q <= DONE_WAIT;
          end
        end
        DISPENSE: begin
          timer_q <= timer_q - 1'b1;
          if (timer_q == TW'(1)) begin
            motor_q <= '0;
            state_q <= DONE_WAIT;
          end
        end
        DONE_WAIT: begin
          // Ack rises one edge after entry, then waits for the requester to drop req.
          if (!done_q) done_q <= 1'b1;
          else if (!reduceInventory) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
